// File: rtl/example_cmd_seq.sv
// Command sequencer: queues RESET/UP/DOWN commands and replays each one as a
// pulse-width-encoded strobe on ctrl, while shadowing the downstream counter.
module example_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       flush,
  input  logic [3:0] step,
  output logic       ctrl,
  output logic       busy,
  output logic       done,
  output logic [3:0] exp_count
);

  localparam int AW = $clog2(DEPTH);
  // Beat counter must hold both the longest pulse (3 beats) and GAP-1.
  localparam int CW = (GAP > 4) ? $clog2(GAP) : 2;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RESET = 2'b01;
  localparam logic [1:0] CMD_UP    = 2'b10;
  localparam logic [1:0] CMD_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP
  } state_t;

  // ---------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          ready_reg;
  logic          empty;
  logic          push;
  logic          pop;
  logic [1:0]    head;

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    cur_cmd_reg;
  logic [3:0]    cur_step_reg;
  logic          ctrl_reg;
  logic          done_reg;
  logic [3:0]    exp_count_reg;

  function automatic logic [CW-1:0] last_beat(input logic [1:0] c);
    logic [CW-1:0] r;
    case (c)
      CMD_RESET: r = CW'(0);
      CMD_DOWN:  r = CW'(1);
      default:   r = CW'(2);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] apply_cmd(input logic [3:0] cur,
                                           input logic [1:0] c,
                                           input logic [3:0] s);
    logic [3:0] r;
    case (c)
      CMD_RESET: r = 4'd0;
      CMD_UP:    r = cur + s;
      CMD_DOWN:  r = cur - s;
      default:   r = cur;
    endcase
    return r;
  endfunction

  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];

  // NOPs complete the handshake but never occupy a slot; flush discards a
  // same-cycle push.
  assign push = cmd_valid & ready_reg & (cmd != CMD_NOP) & ~flush;
  assign pop  = (state_reg == ST_IDLE) & ~empty;

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + (AW+1)'(1);
        2'b01:   count_next = count_reg - (AW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= cmd;
    end
  end

  // ready is registered from the next occupancy, so it never depends on a
  // same-cycle pop and drops to 0 the instant reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      ready_reg <= (count_next != (AW+1)'(DEPTH));
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
      end
    end
  end

  // A popped command is owned by the FSM, so a later flush cannot cut it short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      cur_cmd_reg   <= CMD_NOP;
      cur_step_reg  <= 4'd0;
      ctrl_reg      <= 1'b0;
      done_reg      <= 1'b0;
      exp_count_reg <= 4'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            state_reg    <= ST_PULSE;
            ctrl_reg     <= 1'b1;
            cnt_reg      <= last_beat(head);
            cur_cmd_reg  <= head;
            cur_step_reg <= step;
          end
        end
        ST_PULSE: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_GAP;
            ctrl_reg  <= 1'b0;
            cnt_reg   <= CW'(GAP - 1);
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_reg == '0) begin
            state_reg     <= ST_IDLE;
            exp_count_reg <= apply_cmd(exp_count_reg, cur_cmd_reg, cur_step_reg);
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
            // Arm done so it is high exactly in the final low cycle.
            if (cnt_reg == CW'(1)) begin
              done_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ctrl_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_reg;
  assign ctrl      = ctrl_reg;
  assign done      = done_reg;
  assign exp_count = exp_count_reg;
  assign busy      = (state_reg != ST_IDLE) | ~empty;

endmodule
